// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the clock datapath
// (time counter, alarm and display).
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } time_t;

  function automatic logic time_valid(input time_t t);
    return (t.hour <= HOUR_W'(MAX_HOUR)) && (t.min <= MIN_W'(MAX_MIN));
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) field counter. The counting increment produces the carry;
// the manual bump adds on top of it but never carries.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         bump,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] value_q, value_d;
  logic [W:0]   sum;

  // Sum can reach MAX+2, so a single conditional subtract wraps it.
  always_comb begin
    sum     = {1'b0, value_q} + (W+1)'(inc) + (W+1)'(bump);
    value_d = value_q;
    if (load)
      value_d = load_val;
    else if (sum > (W+1)'(MAX))
      value_d = W'(sum - (W+1)'(MAX + 1));
    else
      value_d = sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc && (value_q == W'(MAX));

endmodule

// File: rtl/time_counter.sv
// 24-hour timekeeper: prescaler producing second events, a sec/min/hour
// carry chain, absolute load with range check, manual field increments.
module time_counter
  import clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        time_load,
  input  logic [10:0] time_set_in,
  input  logic        inc_min,
  input  logic        inc_hour,
  output logic [10:0] time_out,
  output logic [5:0]  sec_out,
  output logic        sec_tick,
  output logic        min_tick,
  output logic        day_tick,
  output logic        load_err
);

  localparam logic [CNT_W-1:0] PRESC_TOP = CNT_W'(CLK_PER_SEC - 1);

  time_t             set_t;
  logic              load_ok, load_bad;
  logic              sec_event, sec_carry, min_carry, hour_carry;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [SEC_W-1:0]  sec_val;
  logic [MIN_W-1:0]  min_val;
  logic [HOUR_W-1:0] hour_val;
  logic              sec_tick_q, min_tick_q, day_tick_q, load_err_q;

  assign set_t     = time_t'(time_set_in);
  assign load_ok   = time_load && time_valid(set_t);
  assign load_bad  = time_load && !time_valid(set_t);
  assign sec_event = run && (presc_q == PRESC_TOP);

  always_comb begin
    presc_d = presc_q;
    if (load_ok)
      presc_d = '0;
    else if (run)
      presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end

  mod_counter #(.MAX(MAX_SEC), .W(SEC_W)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_event),
    .bump     (1'b0),
    .load     (load_ok),
    .load_val ('0),
    .value    (sec_val),
    .carry    (sec_carry)
  );

  // Manual bumps are suppressed by any load request, valid or not.
  mod_counter #(.MAX(MAX_MIN), .W(MIN_W)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_carry),
    .bump     (inc_min && !time_load),
    .load     (load_ok),
    .load_val (set_t.min),
    .value    (min_val),
    .carry    (min_carry)
  );

  mod_counter #(.MAX(MAX_HOUR), .W(HOUR_W)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_carry),
    .bump     (inc_hour && !time_load),
    .load     (load_ok),
    .load_val (set_t.hour),
    .value    (hour_val),
    .carry    (hour_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sec_tick_q <= sec_event  && !load_ok;
      min_tick_q <= sec_carry  && !load_ok;
      day_tick_q <= hour_carry && !load_ok;
      load_err_q <= load_bad;
    end
  end

  assign time_out = {hour_val, min_val};
  assign sec_out  = sec_val;
  assign sec_tick = sec_tick_q;
  assign min_tick = min_tick_q;
  assign day_tick = day_tick_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter with a 4-cycle second.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_time_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        time_load = 1'b0;
  logic [10:0] time_set_in = '0;
  logic        inc_min = 1'b0;
  logic        inc_hour = 1'b0;
  logic [10:0] time_out;
  logic [5:0]  sec_out;
  logic        sec_tick, min_tick, day_tick, load_err;

  int nChecks = 0;
  int nFail = 0;
  int secTicks, minTicks, dayTicks;

  always #5 clk = ~clk;

  time_counter #(.CLK_PER_SEC(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .time_load   (time_load),
    .time_set_in (time_set_in),
    .inc_min     (inc_min),
    .inc_hour    (inc_hour),
    .time_out    (time_out),
    .sec_out     (sec_out),
    .sec_tick    (sec_tick),
    .min_tick    (min_tick),
    .day_tick    (day_tick),
    .load_err    (load_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse time_load for one cycle; returns at the falling edge after the load edge.
  task automatic applyStimulus(input logic [10:0] value);
    time_set_in = value;
    time_load   = 1'b1;
    cycles(1);
    time_load   = 1'b0;
  endtask

  initial begin
    // Asynchronous reset state
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_time", time_out, 11'h000);
    checkOutput("rst_sec", sec_out, 6'd0);
    checkOutput("rst_ticks", {sec_tick, min_tick, day_tick, load_err}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;

    // Reach 05:07:33, then reset mid-count
    applyStimulus(11'h147);
    checkOutput("load_0507", time_out, 11'h147);
    cycles(132);
    checkOutput("at_050733_sec", sec_out, 6'd33);
    checkOutput("at_050733_time", time_out, 11'h147);
    checkOutput("at_050733_tick", sec_tick, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_time", time_out, 11'h000);
    checkOutput("async_rst_sec", sec_out, 6'd0);
    checkOutput("async_rst_tick", sec_tick, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    checkOutput("post_rst_no_tick", sec_tick, 1'b0);
    cycles(1);
    checkOutput("post_rst_tick", sec_tick, 1'b1);
    checkOutput("post_rst_sec", sec_out, 6'd1);

    // 23:59 for 60 seconds -> day rollover
    applyStimulus(11'h5FB);
    checkOutput("load_2359", time_out, 11'h5FB);
    secTicks = 0; minTicks = 0; dayTicks = 0;
    for (int i = 0; i < 240; i++) begin
      cycles(1);
      secTicks += int'(sec_tick);
      minTicks += int'(min_tick);
      dayTicks += int'(day_tick);
      if (i == 238) begin
        checkOutput("pre_roll_sec", sec_out, 6'd59);
        checkOutput("pre_roll_time", time_out, 11'h5FB);
      end
    end
    checkOutput("roll_sec_ticks", secTicks, 60);
    checkOutput("roll_min_ticks", minTicks, 1);
    checkOutput("roll_day_ticks", dayTicks, 1);
    checkOutput("roll_time", time_out, 11'h000);
    checkOutput("roll_sec", sec_out, 6'd0);
    checkOutput("roll_min_tick", min_tick, 1'b1);
    checkOutput("roll_day_tick", day_tick, 1'b1);

    // Rejected loads: hour 24, then minute 60
    applyStimulus(11'h60A);
    checkOutput("err_h24_flag", load_err, 1'b1);
    checkOutput("err_h24_time", time_out, 11'h000);
    cycles(1);
    checkOutput("err_h24_pulse", load_err, 1'b0);
    applyStimulus(11'h03C);
    checkOutput("err_m60_flag", load_err, 1'b1);
    checkOutput("err_m60_time", time_out, 11'h000);
    cycles(1);
    checkOutput("err_m60_pulse", load_err, 1'b0);
    checkOutput("err_keeps_count", sec_out, 6'd1);

    // 10:59:59 + inc_min + second event -> 11:01:00
    applyStimulus(11'h2BB);
    cycles(239);
    checkOutput("at_105959_sec", sec_out, 6'd59);
    inc_min = 1'b1;
    cycles(1);
    inc_min = 1'b0;
    checkOutput("inc_carry_time", time_out, 11'h2C1);
    checkOutput("inc_carry_sec", sec_out, 6'd0);
    checkOutput("inc_carry_ticks", {sec_tick, min_tick, day_tick}, 3'b110);

    // Load coinciding with a second event at 08:29:59
    applyStimulus(11'h21D);
    cycles(239);
    checkOutput("at_082959_sec", sec_out, 6'd59);
    checkOutput("at_082959_time", time_out, 11'h21D);
    applyStimulus(11'h3ED);
    checkOutput("load_evt_time", time_out, 11'h3ED);
    checkOutput("load_evt_sec", sec_out, 6'd0);
    checkOutput("load_evt_ticks", {sec_tick, min_tick, day_tick}, 3'b000);
    cycles(3);
    checkOutput("load_evt_presc", sec_out, 6'd0);
    cycles(1);
    checkOutput("load_evt_next", {sec_tick, sec_out}, {1'b1, 6'd1});

    // Both manual increments at 23:59:20
    applyStimulus(11'h5FB);
    cycles(80);
    checkOutput("at_235920_sec", sec_out, 6'd20);
    inc_min  = 1'b1;
    inc_hour = 1'b1;
    cycles(1);
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    checkOutput("inc_both_time", time_out, 11'h000);
    checkOutput("inc_both_sec", sec_out, 6'd20);
    checkOutput("inc_both_ticks", {sec_tick, min_tick, day_tick}, 3'b000);
    cycles(3);
    checkOutput("inc_both_counts", {sec_tick, sec_out}, {1'b1, 6'd21});

    // run = 0 for 20 cycles at 08:30:10 with prescaler mid-count
    applyStimulus(11'h21E);
    cycles(42);
    checkOutput("at_083010_sec", sec_out, 6'd10);
    run = 1'b0;
    secTicks = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      secTicks += int'(sec_tick);
    end
    checkOutput("stop_no_ticks", secTicks, 0);
    checkOutput("stop_sec", sec_out, 6'd10);
    checkOutput("stop_time", time_out, 11'h21E);
    run = 1'b1;
    cycles(1);
    checkOutput("resume_wait", {sec_tick, sec_out}, {1'b0, 6'd10});
    cycles(1);
    checkOutput("resume_tick", {sec_tick, sec_out}, {1'b1, 6'd11});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
